mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one single-ported SRAM_wrapper instance between the CPU instruction-fetch port (read-only) and the load/store port (read/write), turning the shared memory into a unified instruction/data memory. Each cycle at most one access is granted. Load/store has priority, and a starvation counter guarantees forward progress for fetch. The block drives the SRAM's active-low control pins directly and routes the one-cycle-late read data back to the requester that issued the access.

## Interface
- `ADDR_W`, 14: SRAM word-address width; mapped from request address bits [ADDR_W+1:2].
- `DATA_W`, 32: data width; strobe count is DATA_W/8.
- `STARVE_MAX`, 4: consecutive cycles fetch may be denied before it is forced to win.

- `clk`  in  1: the only clock.
- `rst`  in  1: reset, synchronous and active-low.
- `if_req_valid`  in  1 / `if_req_ready`  out  1 / `if_req_addr`  in  32: fetch request handshake.
- `if_flush`  in  1: squash fetch. Blocks the fetch grant this cycle and suppresses an in-flight fetch response.
- `if_rsp_valid`  out  1 / `if_rsp_data`  out  DATA_W: fetch response.
- `ls_req_valid`  in  1 / `ls_req_ready`  out  1 / `ls_req_we`  in  1 / `ls_req_addr`  in  32: load/store request handshake.
- `ls_req_wdata`  in  DATA_W / `ls_req_wstrb`  in  DATA_W/8: store data and per-byte enables (1 = write byte).
- `ls_rsp_valid`  out  1 / `ls_rsp_data`  out  DATA_W: load data, or store acknowledge.
- `sram_ceb`, `sram_web`  out  1 / `sram_bweb`  out  DATA_W / `sram_a`  out  ADDR_W / `sram_di`  out  DATA_W: SRAM controls, all active-low where applicable.
- `sram_do`  in  DATA_W: SRAM read data, valid the cycle after the access edge.

## Operation
- **Handshake.** Valid/ready. A request is accepted on a cycle where valid & ready. The requester holds valid, addr, we, wdata and wstrb stable until accepted. Ready is combinational and equals that requester's grant.
- **Arbitration.**
  - grant_ls = ls_req_valid & !(force_if).
  - grant_if = if_req_valid & !if_flush & (!ls_req_valid | force_if).
  - force_if = (starve_cnt == STARVE_MAX) & if_req_valid & !if_flush.
- **Starvation counter.**
  - Width $clog2(STARVE_MAX+1).
  - Increments, saturating, when if_req_valid & !if_flush & !grant_if.
  - Clears on grant_if, on !if_req_valid, or on if_flush.
- **SRAM drive (combinational from the grant).**
  - Granted access: sram_ceb=0; sram_a = addr[ADDR_W+1:2].
  - Write: sram_web=0; sram_bweb byte i = {8{~wstrb[i]}}; sram_di = wdata.
  - Read: sram_web=1; sram_bweb = all ones.
  - Idle: ceb=1, web=1, bweb all ones, a=0, di=0.
  - addr[1:0] and the upper address bits are ignored.
- **Response tracker.** Registered owner ∈ {NONE, IF, LS} plus an is_write flag, loaded on every cycle (NONE when there is no grant).
  - if_rsp_valid = (owner==IF) & !if_flush; if_rsp_data = sram_do.
  - ls_rsp_valid = (owner==LS); ls_rsp_data = sram_do for loads, 0 for stores.
- **No response backpressure.** Consumers must take the response in the cycle it is valid.

## Timing
- **Latency.** Accept at edge N; response valid during cycle N+1. Throughput is one access per cycle, back-to-back across requesters.
- **Response vs. new grant.** A response and a new grant to the same or the other requester may occur in the same cycle.
- **Reset (rst=0 at an edge).** owner=NONE and starve_cnt=0.
  - While rst=0: both readies=0, sram_ceb=1, both rsp_valid=0.
  - Reset mid-access discards the pending response.
- **Flush.**
  - if_flush in cycle N+1 drops the fetch response of an access accepted at N.
  - if_flush in cycle N denies the fetch grant in N; load/store is unaffected.
- **Simultaneous requests.** Load/store wins unless force_if. After a forced fetch grant the counter clears, and load/store wins the next contention.

## Structure
- **Package `mem_arb_pkg`:**
  - owner enum (OWN_NONE, OWN_IF, OWN_LS);
  - default STARVE_MAX;
  - function strb2bweb(wstrb) returning the active-low bit mask.
- **Sub-module `mem_arb_starve_ctr`:** saturating counter with inc/clr inputs and an at_max output, instantiated once.
- Everything else is flat in mem_port_arbiter.

## Test plan
1. **Fetch only.** if_req_valid with addrs 0x0, 0x4, 0x8 every cycle; SRAM preloaded word k = k+0x100. Expect if_req_ready=1 each cycle and if_rsp_data = 0x100, 0x101, 0x102 in the following cycles.
2. **Store then load.** Store to 0x10, wdata 0xAABBCCDD, wstrb 4'b0101; then load 0x10 over prior contents 0x11223344. Expect the store ack (ls_rsp_data=0), then load data 0x11BB33DD. During the store, sram_bweb = 0xFF00FF00 and sram_web=0.
3. **Contention and starvation.** Both requesters valid continuously, STARVE_MAX=4. Expect the grant pattern LS, LS, LS, LS, IF, repeating. The fetch address is held stable throughout.
4. **Flush.** Fetch accepted at N; if_flush=1 in N+1. Expect if_rsp_valid=0 in N+1 and no fetch grant in N+1, while a load/store accepted in N+1 still responds in N+2.
5. **Reset mid-operation.** Load accepted at N; rst=0 at edge N+1. Expect ls_rsp_valid=0 after reset, sram_ceb=1 and both readies 0 while rst=0, and normal service one cycle after rst returns to 1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  localparam int unsigned STARVE_MAX_DEF = 4;

  // Widest strobe the helper supports; narrower buses zero-extend and slice.
  localparam int unsigned MAX_STRB_W = 16;
  localparam int unsigned MAX_BWEB_W = 8 * MAX_STRB_W;

  // Per-byte write strobe (1 = write) to the SRAM's active-low bit-write mask.
  function automatic logic [MAX_BWEB_W-1:0] strb2bweb(input logic [MAX_STRB_W-1:0] wstrb);
    logic [MAX_BWEB_W-1:0] bweb;
    bweb = '1;
    for (int i = 0; i < int'(MAX_STRB_W); i++) begin
      bweb[i*8 +: 8] = {8{~wstrb[i]}};
    end
    return bweb;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, load/store and SRAM pin bundle around the memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic              if_req_valid;
  logic              if_req_ready;
  logic [31:0]       if_req_addr;
  logic              if_flush;
  logic              if_rsp_valid;
  logic [DATA_W-1:0] if_rsp_data;

  logic              ls_req_valid;
  logic              ls_req_ready;
  logic              ls_req_we;
  logic [31:0]       ls_req_addr;
  logic [DATA_W-1:0] ls_req_wdata;
  logic [STRB_W-1:0] ls_req_wstrb;
  logic              ls_rsp_valid;
  logic [DATA_W-1:0] ls_rsp_data;

  logic              sram_ceb;
  logic              sram_web;
  logic [DATA_W-1:0] sram_bweb;
  logic [ADDR_W-1:0] sram_a;
  logic [DATA_W-1:0] sram_di;
  logic [DATA_W-1:0] sram_do;

  // Arbiter side.
  modport slave (
    input  if_req_valid, if_req_addr, if_flush,
    output if_req_ready, if_rsp_valid, if_rsp_data,
    input  ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_req_wstrb,
    output ls_req_ready, ls_rsp_valid, ls_rsp_data,
    output sram_ceb, sram_web, sram_bweb, sram_a, sram_di,
    input  sram_do
  );

  // Requester/SRAM environment side.
  modport master (
    output if_req_valid, if_req_addr, if_flush,
    input  if_req_ready, if_rsp_valid, if_rsp_data,
    output ls_req_valid, ls_req_we, ls_req_addr, ls_req_wdata, ls_req_wstrb,
    input  ls_req_ready, ls_rsp_valid, ls_rsp_data,
    input  sram_ceb, sram_web, sram_bweb, sram_a, sram_di,
    output sram_do
  );

endinterface

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the fetch port was denied.
module mem_arb_starve_ctr #(
  parameter int unsigned MAX_VAL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_max
);
  localparam int unsigned CNT_W = (MAX_VAL < 1) ? 1 : $clog2(MAX_VAL + 1);

  logic [CNT_W-1:0] cnt_q;

  // Clear wins over increment; holds at MAX_VAL once reached.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != CNT_W'(MAX_VAL))) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign at_max = (cnt_q == CNT_W'(MAX_VAL));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported SRAM between instruction fetch and load/store.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 14,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic               clk,
  input  logic               rst,
  mem_port_arbiter_if.slave  bus
);

  logic                  if_want;
  logic                  at_max;
  logic                  force_if;
  logic                  grant_if;
  logic                  grant_ls;
  logic                  starve_inc;
  logic                  starve_clr;
  logic [MAX_BWEB_W-1:0] bweb_full;
  owner_e                owner_q;
  owner_e                owner_d;
  logic                  is_write_q;
  logic                  is_write_d;
  logic                  unused_bits;

  // Grant decision: load/store first unless fetch has starved long enough.
  always_comb begin
    if_want    = rst & bus.if_req_valid & ~bus.if_flush;
    force_if   = at_max & if_want;
    grant_ls   = rst & bus.ls_req_valid & ~force_if;
    grant_if   = if_want & (~bus.ls_req_valid | force_if);
    starve_inc = if_want & ~grant_if;
    starve_clr = grant_if | ~if_want;
  end

  assign bus.if_req_ready = grant_if;
  assign bus.ls_req_ready = grant_ls;

  mem_arb_starve_ctr #(
    .MAX_VAL (STARVE_MAX)
  ) u_starve_ctr (
    .clk    (clk),
    .rst    (rst),
    .inc    (starve_inc),
    .clr    (starve_clr),
    .at_max (at_max)
  );

  assign bweb_full = strb2bweb(MAX_STRB_W'(bus.ls_req_wstrb));

  // SRAM pins follow the winning request in the same cycle.
  always_comb begin
    bus.sram_ceb  = 1'b1;
    bus.sram_web  = 1'b1;
    bus.sram_bweb = '1;
    bus.sram_a    = '0;
    bus.sram_di   = '0;
    if (grant_ls) begin
      bus.sram_ceb = 1'b0;
      bus.sram_a   = bus.ls_req_addr[ADDR_W+1:2];
      if (bus.ls_req_we) begin
        bus.sram_web  = 1'b0;
        bus.sram_bweb = bweb_full[DATA_W-1:0];
        bus.sram_di   = bus.ls_req_wdata;
      end
    end else if (grant_if) begin
      bus.sram_ceb = 1'b0;
      bus.sram_a   = bus.if_req_addr[ADDR_W+1:2];
    end
  end

  // Response owner register: who gets next cycle's SRAM read data.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q    <= OWN_NONE;
      is_write_q <= 1'b0;
    end else begin
      owner_q    <= owner_d;
      is_write_q <= is_write_d;
    end
  end

  // Next owner follows this cycle's grant.
  always_comb begin
    owner_d    = OWN_NONE;
    is_write_d = 1'b0;
    if (grant_ls) begin
      owner_d    = OWN_LS;
      is_write_d = bus.ls_req_we;
    end else if (grant_if) begin
      owner_d = OWN_IF;
    end
  end

  // Route late read data; flush squashes a fetch response in flight.
  always_comb begin
    bus.if_rsp_valid = rst & (owner_q == OWN_IF) & ~bus.if_flush;
    bus.if_rsp_data  = bus.sram_do;
    bus.ls_rsp_valid = rst & (owner_q == OWN_LS);
    bus.ls_rsp_data  = is_write_q ? '0 : bus.sram_do;
  end

  // Byte offset and high address bits carry no meaning for a word SRAM.
  assign unused_bits = ^{bus.if_req_addr[31:ADDR_W+2], bus.if_req_addr[1:0],
                         bus.ls_req_addr[31:ADDR_W+2], bus.ls_req_addr[1:0],
                         bweb_full[MAX_BWEB_W-1:DATA_W]};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table plus random traffic.
module tb_mem_port_arbiter;

  localparam int unsigned ADDR_W     = 14;
  localparam int unsigned DATA_W     = 32;
  localparam int          STARVE_MAX = 4;
  localparam int          WORDS      = 1 << ADDR_W;

  typedef struct {
    logic        rst;
    logic        if_v;
    logic [31:0] if_a;
    logic        fl;
    logic        ls_v;
    logic        we;
    logic [31:0] ls_a;
    logic [31:0] wd;
    logic [3:0]  ws;
    logic        e_ifr;
    logic        e_lsr;
    logic        e_ceb;
    logic        e_web;
    logic [31:0] e_bweb;
    logic        e_ifv;
    logic [31:0] e_ifd;
    logic        e_lsv;
    logic [31:0] e_lsd;
  } vec_t;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port SRAM with active-low controls.
  logic [31:0] sram_mem [0:WORDS-1];
  always @(posedge clk) begin
    if (!bus.sram_ceb) begin
      if (!bus.sram_web)
        sram_mem[bus.sram_a] <= (sram_mem[bus.sram_a] & bus.sram_bweb) |
                                (bus.sram_di & ~bus.sram_bweb);
      else
        bus.sram_do <= sram_mem[bus.sram_a];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:WORDS-1];
  int          streak;
  int          pend_kind;
  logic [31:0] pend_data;

  int n_cmp;
  int n_bad;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int word_of(input logic [31:0] addr);
    return int'((addr >> 2) % 32'(WORDS));
  endfunction

  function automatic vec_t mk(
    input logic rst_i, input logic if_v, input logic [31:0] if_a, input logic fl,
    input logic ls_v, input logic we, input logic [31:0] ls_a, input logic [31:0] wd,
    input logic [3:0] ws, input logic e_ifr, input logic e_lsr, input logic e_ceb,
    input logic e_web, input logic [31:0] e_bweb, input logic e_ifv, input logic [31:0] e_ifd,
    input logic e_lsv, input logic [31:0] e_lsd);
    vec_t r;
    r.rst = rst_i; r.if_v = if_v; r.if_a = if_a; r.fl = fl;
    r.ls_v = ls_v; r.we = we; r.ls_a = ls_a; r.wd = wd; r.ws = ws;
    r.e_ifr = e_ifr; r.e_lsr = e_lsr; r.e_ceb = e_ceb; r.e_web = e_web; r.e_bweb = e_bweb;
    r.e_ifv = e_ifv; r.e_ifd = e_ifd; r.e_lsv = e_lsv; r.e_lsd = e_lsd;
    return r;
  endfunction

  // Apply one cycle of inputs, check against the model (and the vector if tbl), advance the model.
  task automatic cycle(input vec_t v, input bit tbl, output bit g_if, output bit g_ls);
    bit          elig;
    logic [31:0] e_bweb;
    logic [31:0] e_a;
    logic [31:0] e_di;
    bit          e_ifv;
    bit          e_lsv;
    int          w;
    rst                  = v.rst;
    bus.if_req_valid     = v.if_v;
    bus.if_req_addr      = v.if_a;
    bus.if_flush         = v.fl;
    bus.ls_req_valid     = v.ls_v;
    bus.ls_req_we        = v.we;
    bus.ls_req_addr      = v.ls_a;
    bus.ls_req_wdata     = v.wd;
    bus.ls_req_wstrb     = v.ws;
    #3;
    elig = v.rst && v.if_v && !v.fl;
    g_ls = v.rst && v.ls_v && !(elig && streak >= STARVE_MAX);
    g_if = elig && !g_ls;
    e_bweb = 32'hFFFF_FFFF;
    e_di   = 32'h0;
    e_a    = 32'h0;
    if (g_ls) begin
      e_a = 32'(word_of(v.ls_a));
      if (v.we) begin
        e_di = v.wd;
        for (int b = 0; b < 4; b++) if (v.ws[b]) e_bweb[8*b +: 8] = 8'h00;
      end
    end else if (g_if) begin
      e_a = 32'(word_of(v.if_a));
    end
    chk("if_req_ready", 32'(bus.if_req_ready), 32'(g_if));
    chk("ls_req_ready", 32'(bus.ls_req_ready), 32'(g_ls));
    chk("sram_ceb", 32'(bus.sram_ceb), 32'(!(g_if || g_ls)));
    chk("sram_web", 32'(bus.sram_web), 32'(!(g_ls && v.we)));
    chk("sram_bweb", bus.sram_bweb, e_bweb);
    chk("sram_a", 32'(bus.sram_a), e_a);
    chk("sram_di", bus.sram_di, e_di);
    e_ifv = v.rst && (pend_kind == 1) && !v.fl;
    e_lsv = v.rst && (pend_kind == 2);
    chk("if_rsp_valid", 32'(bus.if_rsp_valid), 32'(e_ifv));
    if (e_ifv) chk("if_rsp_data", bus.if_rsp_data, pend_data);
    chk("ls_rsp_valid", 32'(bus.ls_rsp_valid), 32'(e_lsv));
    if (e_lsv) chk("ls_rsp_data", bus.ls_rsp_data, pend_data);
    if (tbl) begin
      chk("vec_if_ready", 32'(bus.if_req_ready), 32'(v.e_ifr));
      chk("vec_ls_ready", 32'(bus.ls_req_ready), 32'(v.e_lsr));
      chk("vec_ceb", 32'(bus.sram_ceb), 32'(v.e_ceb));
      chk("vec_web", 32'(bus.sram_web), 32'(v.e_web));
      chk("vec_bweb", bus.sram_bweb, v.e_bweb);
      chk("vec_if_rsp_valid", 32'(bus.if_rsp_valid), 32'(v.e_ifv));
      if (v.e_ifv) chk("vec_if_rsp_data", bus.if_rsp_data, v.e_ifd);
      chk("vec_ls_rsp_valid", 32'(bus.ls_rsp_valid), 32'(v.e_lsv));
      if (v.e_lsv) chk("vec_ls_rsp_data", bus.ls_rsp_data, v.e_lsd);
    end
    if (!v.rst) begin
      streak    = 0;
      pend_kind = 0;
    end else begin
      if (elig && !g_if) streak = (streak < STARVE_MAX) ? streak + 1 : streak;
      else streak = 0;
      pend_kind = 0;
      if (g_ls) begin
        w = word_of(v.ls_a);
        pend_kind = 2;
        pend_data = v.we ? 32'h0 : ref_mem[w];
        if (v.we)
          for (int b = 0; b < 4; b++)
            if (v.ws[b]) ref_mem[w][8*b +: 8] = v.wd[8*b +: 8];
      end else if (g_if) begin
        pend_kind = 1;
        pend_data = ref_mem[word_of(v.if_a)];
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];
  vec_t c;
  bit   gi;
  bit   gl;

  initial begin
    localparam logic [31:0] FF = 32'hFFFF_FFFF;
    n_cmp = 0; n_bad = 0; streak = 0; pend_kind = 0; pend_data = 32'h0;
    for (int k = 0; k < WORDS; k++) begin
      sram_mem[k] = 32'(k) + 32'h100;
      ref_mem[k]  = 32'(k) + 32'h100;
    end
    sram_mem[4] = 32'h1122_3344;
    ref_mem[4]  = 32'h1122_3344;
    rst = 1'b0;
    bus.if_req_valid = 1'b0; bus.if_req_addr = 32'h0; bus.if_flush = 1'b0;
    bus.ls_req_valid = 1'b0; bus.ls_req_we = 1'b0; bus.ls_req_addr = 32'h0;
    bus.ls_req_wdata = 32'h0; bus.ls_req_wstrb = 4'h0;
    @(posedge clk);
    #1;

    //           rst ifv if_a        fl lsv we ls_a        wdata         ws      ifr lsr ceb web bweb          ifv ifd           lsv lsd
    vecs.push_back(mk(0, 0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        4'h0,  0, 0, 1, 1, FF,           0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h0,  0, 1, 0, 32'h0,  32'h0,        4'h0,  0, 0, 1, 1, FF,           0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h0,  0, 0, 0, 32'h0,  32'h0,        4'h0,  1, 0, 0, 1, FF,           0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h4,  0, 0, 0, 32'h0,  32'h0,        4'h0,  1, 0, 0, 1, FF,           1, 32'h100,      0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h8,  0, 0, 0, 32'h0,  32'h0,        4'h0,  1, 0, 0, 1, FF,           1, 32'h101,      0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        4'h0,  0, 0, 1, 1, FF,           1, 32'h102,      0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,  0, 1, 1, 32'h10, 32'hAABBCCDD, 4'h5,  0, 1, 0, 0, 32'hFF00FF00, 0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,  0, 1, 0, 32'h10, 32'h0,        4'h0,  0, 1, 0, 1, FF,           0, 32'h0,        1, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        4'h0,  0, 0, 1, 1, FF,           0, 32'h0,        1, 32'h11BB33DD));
    vecs.push_back(mk(1, 1, 32'hC,  0, 0, 0, 32'h0,  32'h0,        4'h0,  1, 0, 0, 1, FF,           0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 1, 32'h10, 1, 1, 0, 32'h8,  32'h0,        4'h0,  0, 1, 0, 1, FF,           0, 32'h0,        0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,  0, 0, 0, 32'h0,  32'h0,        4'h0,  0, 0, 1, 1, FF,           0, 32'h0,        1, 32'h102));
    foreach (vecs[i]) cycle(vecs[i], 1'b1, gi, gl);

    // Continuous contention: four load/store grants, then a forced fetch, repeating.
    begin
      int  k;
      bit  want_if;
      bit  prev_if;
      bit  prev_ls;
      k = 0; prev_if = 1'b0; prev_ls = 1'b0;
      for (int i = 0; i < 10; i++) begin
        want_if = ((i % 5) == 4);
        c = mk(1, 1, 32'h20, 0, 1, 0, 32'h40 + 32'(4 * k), 32'h0, 4'h0,
               want_if, !want_if, 0, 1, FF,
               prev_if, 32'h108, prev_ls, 32'h110 + 32'(k - 1));
        cycle(c, 1'b1, gi, gl);
        prev_if = want_if;
        prev_ls = !want_if;
        if (!want_if) k++;
      end
    end

    // Reset while a load is in flight drops its response; service resumes right after.
    cycle(mk(1, 0, 32'h0, 0, 1, 0, 32'h14, 32'h0, 4'h0, 0, 1, 0, 1, FF, 1, 32'h108, 0, 32'h0), 1'b1, gi, gl);
    cycle(mk(0, 1, 32'h0, 0, 1, 0, 32'h18, 32'h0, 4'h0, 0, 0, 1, 1, FF, 0, 32'h0,   0, 32'h0), 1'b1, gi, gl);
    cycle(mk(1, 0, 32'h0, 0, 1, 0, 32'h18, 32'h0, 4'h0, 0, 1, 0, 1, FF, 0, 32'h0,   0, 32'h0), 1'b1, gi, gl);
    cycle(mk(1, 0, 32'h0, 0, 0, 0, 32'h0,  32'h0, 4'h0, 0, 0, 1, 1, FF, 0, 32'h0,   1, 32'h106), 1'b1, gi, gl);

    // Random traffic; requests are held until accepted.
    begin
      bit hold_if;
      bit hold_ls;
      hold_if = 1'b0; hold_ls = 1'b0;
      c = mk(1, 0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
      for (int i = 0; i < 400; i++) begin
        if (!hold_if) begin
          c.if_v = ($urandom_range(0, 9) < 7);
          c.if_a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3)) |
                   (32'($urandom_range(0, 3)) << 20);
        end
        if (!hold_ls) begin
          c.ls_v = ($urandom_range(0, 9) < 6);
          c.we   = 1'($urandom_range(0, 1));
          c.ls_a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3)) |
                   (32'($urandom_range(0, 3)) << 24);
          c.wd   = $urandom;
          c.ws   = 4'($urandom_range(0, 15));
        end
        c.fl  = ($urandom_range(0, 9) == 0);
        c.rst = ($urandom_range(0, 39) != 0);
        cycle(c, 1'b0, gi, gl);
        hold_if = c.if_v && !gi;
        hold_ls = c.ls_v && !gl;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
